mandel_pixel_collector: RTL and testbench

Downstream stage of the per-batch coordinate distributor. Collects the iteration counts of the NUM_ENGINES pixel engines once all of them report done, maps each count to an RGB pixel and streams the batch in raster order on a valid/ready pixel interface. It also pulses `fin_flag` to advance the distributor, so engines recompute the next batch while the current one drains.

---
 rtl/mandel_pkg.sv | 18 +
 rtl/mandel_colour_map.sv | 26 ++
 rtl/mandel_pixel_collector.sv | 130 +++++++++++++
 tb/tb_mandel_pixel_collector.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared types and colour-map constants for the Mandelbrot pixel collector.
package mandel_pkg;

  typedef enum logic [0:0] {
    ST_WAIT   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  localparam int CHAN_W = 8;
  localparam int RGB_W  = 3 * CHAN_W;

  localparam logic [RGB_W-1:0] INSIDE_RGB = {RGB_W{1'b0}};

  function automatic logic [RGB_W-1:0] grey_rgb(input logic [CHAN_W-1:0] g);
    return {g, g, g};
  endfunction

endpackage

// File: rtl/mandel_colour_map.sv
// Combinational iteration-count to pixel mapping: inside-set points are black,
// escaping points become a grey level taken from the low count byte.
module mandel_colour_map
  import mandel_pkg::*;
#(
  parameter int ITER_WIDTH       = 16,
  parameter int MAX_ITER         = 255,
  parameter int PIXEL_DATA_WIDTH = 32
) (
  input  logic [ITER_WIDTH-1:0]       iter_i,
  output logic [PIXEL_DATA_WIDTH-1:0] pixel_o
);

  localparam logic [ITER_WIDTH-1:0] MAX_ITER_C = ITER_WIDTH'(MAX_ITER);

  // Grey ramp for escaping points, black for points inside the set
  always_comb begin
    pixel_o = '0;
    if (iter_i >= MAX_ITER_C) begin
      pixel_o[RGB_W-1:0] = INSIDE_RGB;
    end else begin
      pixel_o[RGB_W-1:0] = grey_rgb(iter_i[CHAN_W-1:0]);
    end
  end

endmodule

// File: rtl/mandel_pixel_collector.sv
// Captures one batch of engine results when every engine is done, then streams
// the mapped pixels in raster order while the engines compute the next batch.
module mandel_pixel_collector
  import mandel_pkg::*;
#(
  parameter int PIXEL_DATA_WIDTH = 32,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int NUM_ENGINES      = 6,
  parameter int ITER_WIDTH       = 16,
  parameter int MAX_ITER         = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_ENGINES-1:0]      eng_done,
  input  logic [ITER_WIDTH-1:0]       eng_iter [NUM_ENGINES],
  output logic                        fin_flag,
  output logic [PIXEL_DATA_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sof,
  output logic                        out_eol
);

  localparam int X_W   = $clog2(SCREEN_WIDTH);
  localparam int Y_W   = $clog2(SCREEN_HEIGHT);
  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  localparam logic [X_W-1:0]   X_LAST   = X_W'(SCREEN_WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(SCREEN_HEIGHT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENGINES - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic                  fin_q, fin_d;
  logic                  capture_s;

  logic [PIXEL_DATA_WIDTH-1:0] pix_s [NUM_ENGINES];
  logic [PIXEL_DATA_WIDTH-1:0] buf_q [NUM_ENGINES];

  for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_map
    mandel_colour_map #(
      .ITER_WIDTH      (ITER_WIDTH),
      .MAX_ITER        (MAX_ITER),
      .PIXEL_DATA_WIDTH(PIXEL_DATA_WIDTH)
    ) u_map (
      .iter_i (eng_iter[g]),
      .pixel_o(pix_s[g])
    );
  end

  // Next-state: capture on all-done in WAIT, advance index and raster on each transfer
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    x_d       = x_q;
    y_d       = y_q;
    fin_d     = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (&eng_done) begin
          capture_s = 1'b1;
          idx_d     = '0;
          fin_d     = 1'b1;
          state_d   = ST_STREAM;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d = '0;
            end else begin
              y_d = y_q + Y_W'(1);
            end
          end else begin
            x_d = x_q + X_W'(1);
          end
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_WAIT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Control and raster-position registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fin_q   <= fin_d;
    end
  end

  // Pixel buffer keeps its contents across reset; it is only read while streaming
  always_ff @(posedge clk) begin
    if (capture_s) begin
      buf_q <= pix_s;
    end
  end

  assign fin_flag  = fin_q;
  assign out_valid = (state_q == ST_STREAM);
  assign out_data  = buf_q[idx_q];
  assign out_sof   = (x_q == '0) && (y_q == '0);
  assign out_eol   = (x_q == X_LAST);

endmodule

// File: tb/tb_mandel_pixel_collector.sv
// Scoreboard bench: two collector instances (full-screen and tiny-screen) fed by
// engine-style drivers; a negedge monitor checks every beat against a raster model.
module tb_mandel_pixel_collector;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eol;
  } exp_t;

  logic        clk;
  logic        reset;

  logic [5:0]  a_done;
  logic [15:0] a_iter [6];
  logic        a_fin, a_valid, a_ready, a_sof, a_eol;
  logic [31:0] a_data;

  logic [2:0]  b_done;
  logic [15:0] b_iter [3];
  logic        b_fin, b_valid, b_ready, b_sof, b_eol;
  logic [31:0] b_data;

  int checks   = 0;
  int failures = 0;
  int pix[2]      = '{0, 0};
  int beats[2]    = '{0, 0};
  int sofs[2]     = '{0, 0};
  int rdy_mode[2] = '{0, 0};
  logic        pv[2], ps[2], psof[2], peol[2];
  logic [31:0] pd[2];
  exp_t q_a[$];
  exp_t q_b[$];

  mandel_pixel_collector #(
    .PIXEL_DATA_WIDTH(32), .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480),
    .NUM_ENGINES(6), .ITER_WIDTH(16), .MAX_ITER(255)
  ) dut_a (
    .clk(clk), .reset(reset), .eng_done(a_done), .eng_iter(a_iter),
    .fin_flag(a_fin), .out_data(a_data), .out_valid(a_valid),
    .out_ready(a_ready), .out_sof(a_sof), .out_eol(a_eol)
  );

  mandel_pixel_collector #(
    .PIXEL_DATA_WIDTH(32), .SCREEN_WIDTH(8), .SCREEN_HEIGHT(4),
    .NUM_ENGINES(3), .ITER_WIDTH(16), .MAX_ITER(255)
  ) dut_b (
    .clk(clk), .reset(reset), .eng_done(b_done), .eng_iter(b_iter),
    .fin_flag(b_fin), .out_data(b_data), .out_valid(b_valid),
    .out_ready(b_ready), .out_sof(b_sof), .out_eol(b_eol)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_pix(input logic [15:0] it);
    if (it >= 16'd255) return 32'h0000_0000;
    return {8'h00, it[7:0], it[7:0], it[7:0]};
  endfunction

  // Raster model: global pixel count modulo frame size gives (x,y)
  task automatic push_exp(input int sel, input logic [15:0] it);
    int   w, h, pos;
    exp_t e;
    w = (sel == 0) ? 640 : 8;
    h = (sel == 0) ? 480 : 4;
    pos    = pix[sel] % (w * h);
    e.data = ref_pix(it);
    e.sof  = (pos == 0);
    e.eol  = ((pos % w) == (w - 1));
    if (sel == 0) q_a.push_back(e);
    else          q_b.push_back(e);
    pix[sel]++;
  endtask

  function automatic logic [15:0] rnd_iter();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(250, 260));
      1:       return 16'($urandom);
      default: return 16'($urandom_range(0, 254));
    endcase
  endfunction

  function automatic logic rdy_val(input int mode, input int ph);
    case (mode)
      0:       return 1'b1;
      1:       return ((ph % 4) == 0) || ((ph % 4) == 3);
      default: return 1'b1 & 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic mon_step(input int sel, input logic rst, input logic valid,
                          input logic ready, input logic fin, input logic [31:0] data,
                          input logic sof, input logic eol);
    exp_t e;
    int   qs;
    if (rst) begin
      pv[sel] = 1'b0;
      ps[sel] = 1'b0;
      return;
    end
    chk($sformatf("fin_pulse_%0d", sel), {31'd0, fin}, {31'd0, valid && !pv[sel]});
    if (valid) begin
      if (ps[sel]) begin
        chk($sformatf("stall_data_%0d", sel), data, pd[sel]);
        chk($sformatf("stall_sof_%0d", sel), {31'd0, sof}, {31'd0, psof[sel]});
        chk($sformatf("stall_eol_%0d", sel), {31'd0, eol}, {31'd0, peol[sel]});
      end
      qs = (sel == 0) ? q_a.size() : q_b.size();
      chk($sformatf("unexpected_valid_%0d", sel), {31'd0, qs != 0}, 32'd1);
      if (ready && qs != 0) begin
        e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
        chk($sformatf("beat_data_%0d", sel), data, e.data);
        chk($sformatf("beat_sof_%0d", sel), {31'd0, sof}, {31'd0, e.sof});
        chk($sformatf("beat_eol_%0d", sel), {31'd0, eol}, {31'd0, e.eol});
        beats[sel]++;
        if (sof) sofs[sel]++;
      end
    end
    pv[sel]   = valid;
    ps[sel]   = valid && !ready;
    pd[sel]   = data;
    psof[sel] = sof;
    peol[sel] = eol;
  endtask

  always @(negedge clk) begin
    mon_step(0, reset, a_valid, a_ready, a_fin, a_data, a_sof, a_eol);
    mon_step(1, reset, b_valid, b_ready, b_fin, b_data, b_sof, b_eol);
  end

  initial begin
    int ph;
    ph      = 0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      a_ready = rdy_val(rdy_mode[0], ph);
      b_ready = rdy_val(rdy_mode[1], ph);
    end
  end

  task automatic wait_drain(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? q_a.size() : q_b.size()) != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain_%0d", sel), {31'd0, n < 5000}, 32'd1);
  endtask

  // Engine behaviour: present results, hold done until fin_flag is sampled
  task automatic issue_a(input logic [15:0] it [6]);
    int n;
    for (int i = 0; i < 6; i++) begin
      a_iter[i] = it[i];
      push_exp(0, it[i]);
    end
    a_done = 6'h3f;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (a_fin) break;
      n++;
    end
    chk("fin_seen_a", {31'd0, n < 500}, 32'd1);
    @(posedge clk);
    #1;
    a_done = 6'h00;
  endtask

  task automatic issue_b(input logic [15:0] it [3]);
    int n;
    for (int i = 0; i < 3; i++) begin
      b_iter[i] = it[i];
      push_exp(1, it[i]);
    end
    b_done = 3'h7;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (b_fin) break;
      n++;
    end
    chk("fin_seen_b", {31'd0, n < 500}, 32'd1);
    @(posedge clk);
    #1;
    b_done = 3'h0;
  endtask

  // Idle-start capture with latency check, optionally preceded by a partial-done hold
  task automatic capture_a(input logic [15:0] it [6], input bit partial);
    wait_drain(0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      a_iter[i] = it[i];
      push_exp(0, it[i]);
    end
    if (partial) begin
      a_done = 6'b011111;
      repeat (20) @(posedge clk);
      #1;
      chk("partial_valid", {31'd0, a_valid}, 32'd0);
      chk("partial_fin", {31'd0, a_fin}, 32'd0);
    end
    a_done = 6'h3f;
    @(posedge clk);
    #1;
    chk("capture_valid", {31'd0, a_valid}, 32'd1);
    chk("capture_fin", {31'd0, a_fin}, 32'd1);
    @(posedge clk);
    #1;
    a_done = 6'h00;
  endtask

  initial begin
    logic [15:0] it [6];
    logic [15:0] itb [3];
    int base, n;

    reset  = 1'b1;
    a_done = 6'h00;
    b_done = 3'h0;
    for (int i = 0; i < 6; i++) a_iter[i] = 16'd0;
    for (int i = 0; i < 3; i++) b_iter[i] = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_a", {31'd0, a_valid}, 32'd0);
    chk("reset_fin_a", {31'd0, a_fin}, 32'd0);
    chk("reset_valid_b", {31'd0, b_valid}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_valid_a", {31'd0, a_valid}, 32'd0);

    it = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    capture_a(it, 1'b0);

    for (int i = 0; i < 6; i++) it[i] = rnd_iter();
    capture_a(it, 1'b1);

    it = '{16'd255, 16'd300, 16'd254, 16'd256, 16'd65535, 16'd128};
    capture_a(it, 1'b0);
    wait_drain(0);

    rdy_mode[0] = 1;
    repeat (4) begin
      for (int i = 0; i < 6; i++) it[i] = rnd_iter();
      issue_a(it);
    end
    wait_drain(0);

    rdy_mode[0] = 2;
    repeat (8) begin
      for (int i = 0; i < 6; i++) it[i] = rnd_iter();
      issue_a(it);
    end
    wait_drain(0);
    rdy_mode[0] = 0;

    for (int k = 0; k < 11; k++) begin
      rdy_mode[1] = (k < 6) ? 0 : 2;
      for (int i = 0; i < 3; i++) itb[i] = rnd_iter();
      issue_b(itb);
    end
    wait_drain(1);
    chk("b_beats", beats[1], 32'd33);
    chk("b_sof_count", sofs[1], 32'd2);
    rdy_mode[1] = 0;

    @(posedge clk);
    #1;
    base = beats[0];
    for (int i = 0; i < 6; i++) it[i] = rnd_iter();
    issue_a(it);
    n = 0;
    while (beats[0] < base + 2 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reset_wait", {31'd0, n < 100}, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_valid", {31'd0, a_valid}, 32'd0);
    chk("midreset_fin", {31'd0, a_fin}, 32'd0);
    q_a.delete();
    q_b.delete();
    pix    = '{0, 0};
    a_done = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    base  = sofs[0];
    for (int i = 0; i < 6; i++) it[i] = rnd_iter();
    capture_a(it, 1'b0);
    wait_drain(0);
    chk("post_reset_sof", sofs[0] - base, 32'd1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
